// File: rtl/bit16to32_packer.sv
// bit16to32_packer
//   Packs a valid/ready stream of HALF_W-bit halfwords into 2*HALF_W-bit words
//   held in one registered output stage. Sustains one word per two input beats
//   with no bubbles. The first beat lands in the upper half when HI_FIRST=1.
//
//   Optional feature, compiled in with `define PACK_LAST_EN:
//     adds IN_LAST / OUT_LAST and the PAD parameter, so that a stream can end
//     on an odd halfword. The lone halfword is emitted padded with PAD.
//   With PACK_LAST_EN undefined, every word is built from exactly two beats.
module bit16to32_packer #(
  parameter int          HALF_W   = 16,
  parameter bit          HI_FIRST = 1'b1,
  parameter int          CNT_W    = 16
`ifdef PACK_LAST_EN
  ,
  parameter logic [HALF_W-1:0] PAD = '0
`endif
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                IN_VALID,
  output logic                IN_READY,
  input  logic [HALF_W-1:0]   INPT,
`ifdef PACK_LAST_EN
  input  logic                IN_LAST,
  output logic                OUT_LAST,
`endif
  output logic                OUT_VALID,
  input  logic                OUT_READY,
  output logic [2*HALF_W-1:0] OTPT,
  output logic                PHASE,
  output logic [CNT_W-1:0]    WORD_CNT
);

  // PHASE encoding: waiting for the first half, or holding the first half.
  localparam logic S_FIRST  = 1'b0;
  localparam logic S_SECOND = 1'b1;

  // State registers and their next-state values.
  logic                phase_q,     phase_d;
  logic [HALF_W-1:0]   hold_q,      hold_d;
  logic [2*HALF_W-1:0] otpt_q,      otpt_d;
  logic                out_valid_q, out_valid_d;
  logic [CNT_W-1:0]    word_cnt_q,  word_cnt_d;
`ifdef PACK_LAST_EN
  logic                out_last_q,  out_last_d;
`endif

  // Handshake decode.
  logic                slot_free;   // output register can take a word this cycle
  logic                short_word;  // lone final halfword arriving in S_FIRST
  logic                in_ready;
  logic                accept;      // halfword taken this cycle
  logic                load;        // a complete word enters the output register
  logic                drain;       // the held word is consumed this cycle
  logic [2*HALF_W-1:0] packed_word;

  // Input readiness: the first beat only needs the hold register, which is
  // always free in S_FIRST, so backpressure stalls only the completing beat.
  always_comb begin
    // NOTE: every signal written here gets a value on every path, starting
    // with these defaults; otherwise synthesis infers a latch.
    slot_free  = !out_valid_q || OUT_READY;
    short_word = 1'b0;
`ifdef PACK_LAST_EN
    short_word = (phase_q == S_FIRST) && IN_LAST;
`endif
    if ((phase_q == S_SECOND) || short_word) begin
      in_ready = slot_free;
    end else begin
      in_ready = 1'b1;
    end
    accept = IN_VALID && in_ready;
    load   = accept && ((phase_q == S_SECOND) || short_word);
    drain  = out_valid_q && OUT_READY;
  end

  // Word assembly from the held first half and the current beat. Only the
  // registered copy reaches OTPT, so INPT never has a combinational path out.
  always_comb begin
    packed_word = '0;
    if (short_word) begin
`ifdef PACK_LAST_EN
      packed_word = HI_FIRST ? {INPT, PAD} : {PAD, INPT};
`endif
    end else if (HI_FIRST) begin
      packed_word = {hold_q, INPT};
    end else begin
      packed_word = {INPT, hold_q};
    end
  end

  // Next-state logic for the phase FSM, hold register, output stage and counter.
  always_comb begin
    phase_d     = phase_q;
    hold_d      = hold_q;
    otpt_d      = otpt_q;
    out_valid_d = out_valid_q;
    word_cnt_d  = word_cnt_q;
`ifdef PACK_LAST_EN
    out_last_d  = out_last_q;
`endif

    // Phase and hold register. A lone final halfword leaves the FSM in S_FIRST.
    if (accept) begin
      if (phase_q == S_FIRST) begin
        if (!short_word) begin
          hold_d  = INPT;
          phase_d = S_SECOND;
        end
      end else begin
        phase_d = S_FIRST;
      end
    end

    // Output stage: a load wins over a drain, so a simultaneous load and
    // drain keeps OUT_VALID high with fresh data. OTPT is held after a drain.
    if (load) begin
      otpt_d      = packed_word;
      out_valid_d = 1'b1;
`ifdef PACK_LAST_EN
      out_last_d  = IN_LAST;
`endif
    end else if (drain) begin
      out_valid_d = 1'b0;
    end

    // Emitted-word counter, wraps silently.
    if (drain) begin
      word_cnt_d = word_cnt_q + CNT_W'(1);
    end
  end

  // State update with asynchronous reset; a partial halfword and any
  // unconsumed word are discarded.
  always_ff @(posedge CLK or negedge RST_N) begin
    // NOTE: every register here is cleared in the reset branch (there is no
    // memory array to leave unreset), and all updates use non-blocking
    // assignments so each register sees the previous-cycle values of the others.
    if (!RST_N) begin
      phase_q     <= S_FIRST;
      hold_q      <= '0;
      otpt_q      <= '0;
      out_valid_q <= 1'b0;
      word_cnt_q  <= '0;
`ifdef PACK_LAST_EN
      out_last_q  <= 1'b0;
`endif
    end else begin
      phase_q     <= phase_d;
      hold_q      <= hold_d;
      otpt_q      <= otpt_d;
      out_valid_q <= out_valid_d;
      word_cnt_q  <= word_cnt_d;
`ifdef PACK_LAST_EN
      out_last_q  <= out_last_d;
`endif
    end
  end

  // Output drive.
  assign IN_READY  = in_ready;
  assign OUT_VALID = out_valid_q;
  assign OTPT      = otpt_q;
  assign PHASE     = phase_q;
  assign WORD_CNT  = word_cnt_q;
`ifdef PACK_LAST_EN
  assign OUT_LAST  = out_last_q;
`endif

endmodule

// File: tb/tb_bit16to32_packer.sv
// Self-checking bench for bit16to32_packer.
//   Two instances share one input stream: u_dut_a (HI_FIRST=1, CNT_W=16) and
//   u_dut_b (HI_FIRST=0, CNT_W=4, so counter wrap is reachable quickly).
//   A transaction-level model (pending halfword + one output slot + a word
//   count) predicts both, and a negedge process compares every cycle.
module tb_bit16to32_packer;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b1;
  logic        IN_VALID = 1'b0;
  logic [15:0] INPT = '0;
  logic        OUT_READY = 1'b0;

  logic        in_ready_a, out_valid_a, phase_a;
  logic [31:0] otpt_a;
  logic [15:0] cnt_a;
  logic        in_ready_b, out_valid_b, phase_b;
  logic [31:0] otpt_b;
  logic [3:0]  cnt_b;
`ifdef PACK_LAST_EN
  logic        last_a, last_b;
`endif

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  always #5 CLK = ~CLK;

  bit16to32_packer #(.HALF_W(16), .HI_FIRST(1'b1), .CNT_W(16)) u_dut_a (
    .CLK(CLK), .RST_N(RST_N), .IN_VALID(IN_VALID), .IN_READY(in_ready_a), .INPT(INPT),
`ifdef PACK_LAST_EN
    .IN_LAST(1'b0), .OUT_LAST(last_a),
`endif
    .OUT_VALID(out_valid_a), .OUT_READY(OUT_READY), .OTPT(otpt_a),
    .PHASE(phase_a), .WORD_CNT(cnt_a)
  );

  bit16to32_packer #(.HALF_W(16), .HI_FIRST(1'b0), .CNT_W(4)) u_dut_b (
    .CLK(CLK), .RST_N(RST_N), .IN_VALID(IN_VALID), .IN_READY(in_ready_b), .INPT(INPT),
`ifdef PACK_LAST_EN
    .IN_LAST(1'b0), .OUT_LAST(last_b),
`endif
    .OUT_VALID(out_valid_b), .OUT_READY(OUT_READY), .OTPT(otpt_b),
    .PHASE(phase_b), .WORD_CNT(cnt_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // m_have/m_half : a first halfword is waiting for its partner
  // m_slot_v      : a finished word (m_first, m_second in arrival order) is offered
  // m_cnt         : number of words consumed since reset
  bit          m_have = 1'b0;
  logic [15:0] m_half = '0;
  bit          m_slot_v = 1'b0;
  logic [15:0] m_first = '0, m_second = '0;
  logic [31:0] m_cnt = '0;
  bit          m_acc = 1'b0;      // last edge accepted a beat
  logic        m_ready, m_take, m_drain, m_pair;

  // A beat is refused only when it would complete a word and the slot is
  // full and not being emptied this cycle.
  assign m_ready = !m_have || !m_slot_v || OUT_READY;
  assign m_take  = IN_VALID && m_ready;
  assign m_drain = m_slot_v && OUT_READY;
  assign m_pair  = m_take && m_have;

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      m_have <= 1'b0; m_half <= '0; m_slot_v <= 1'b0;
      m_first <= '0; m_second <= '0; m_cnt <= '0; m_acc <= 1'b0;
    end else begin
      m_acc <= m_take;
      if (m_drain) m_cnt <= m_cnt + 32'd1;
      if (m_pair) begin
        m_first <= m_half; m_second <= INPT; m_slot_v <= 1'b1; m_have <= 1'b0;
      end else begin
        if (m_take) begin m_half <= INPT; m_have <= 1'b1; end
        if (m_drain) m_slot_v <= 1'b0;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge CLK) begin
    if (chk_en) begin
      check("in_ready_a", 32'(in_ready_a), 32'(m_ready));
      check("in_ready_b", 32'(in_ready_b), 32'(m_ready));
      check("out_valid_a", 32'(out_valid_a), 32'(m_slot_v));
      check("out_valid_b", 32'(out_valid_b), 32'(m_slot_v));
      check("otpt_a", otpt_a, {m_first, m_second});
      check("otpt_b", otpt_b, {m_second, m_first});
      check("phase_a", 32'(phase_a), 32'(m_have));
      check("phase_b", 32'(phase_b), 32'(m_have));
      check("word_cnt_a", 32'(cnt_a), 32'(m_cnt[15:0]));
      check("word_cnt_b", 32'(cnt_b), 32'(m_cnt[3:0]));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(negedge CLK);
    #1;
  endtask

  task automatic drive(input bit v, input logic [15:0] d, input bit r);
    IN_VALID  = v;
    INPT      = d;
    OUT_READY = r;
  endtask

  task automatic step(input bit v, input logic [15:0] d, input bit r);
    drive(v, d, r);
    tick();
  endtask

  task automatic do_reset();
    drive(1'b0, 16'h0, 1'b0);
    RST_N = 1'b0;
    tick();
    tick();
    RST_N = 1'b1;
  endtask

  initial begin
    #1;
    RST_N  = 1'b0;
    chk_en = 1'b1;
    tick();
    tick();
    // Reset values.
    check("rst_out_valid", 32'(out_valid_a), 32'd0);
    check("rst_otpt", otpt_a, 32'h0);
    check("rst_phase", 32'(phase_a), 32'd0);
    check("rst_cnt", 32'(cnt_a), 32'd0);
    RST_N = 1'b1;

    // Basic pack, both orders.
    step(1'b1, 16'hDEAD, 1'b1);
    check("t1_phase_held", 32'(phase_a), 32'd1);
    step(1'b1, 16'hBEEF, 1'b1);
    check("t1_otpt_hi_first", otpt_a, 32'hDEADBEEF);
    check("t1_otpt_lo_first", otpt_b, 32'hBEEFDEAD);
    check("t1_out_valid", 32'(out_valid_a), 32'd1);
    step(1'b0, 16'h0, 1'b1);
    check("t1_word_cnt", 32'(cnt_a), 32'd1);
    check("t1_valid_fell", 32'(out_valid_a), 32'd0);
    check("t1_otpt_held", otpt_a, 32'hDEADBEEF);

    // Backpressure: second beat of the next word stalls, first beat does not.
    step(1'b1, 16'h000A, 1'b0);
    step(1'b1, 16'h000B, 1'b0);
    check("t3_otpt_ab", otpt_a, 32'h000A000B);
    drive(1'b1, 16'h000C, 1'b0);
    #1;
    check("t3_ready_first_beat", 32'(in_ready_a), 32'd1);
    tick();
    drive(1'b1, 16'h000D, 1'b0);
    #1;
    check("t3_ready_stalled", 32'(in_ready_a), 32'd0);
    tick();
    check("t3_otpt_stable", otpt_a, 32'h000A000B);
    drive(1'b1, 16'h000D, 1'b1);
    #1;
    check("t3_ready_released", 32'(in_ready_a), 32'd1);
    tick();
    check("t3_otpt_cd", otpt_a, 32'h000C000D);
    check("t3_otpt_cd_b", otpt_b, 32'h000D000C);
    check("t3_valid_kept", 32'(out_valid_a), 32'd1);
    check("t3_cnt", 32'(cnt_a), 32'd2);
    step(1'b0, 16'h0, 1'b1);

    // Reset with a partial halfword held.
    step(1'b1, 16'h1234, 1'b1);
    do_reset();
    check("t4_phase", 32'(phase_a), 32'd0);
    check("t4_out_valid", 32'(out_valid_a), 32'd0);
    step(1'b1, 16'h5678, 1'b1);
    step(1'b1, 16'h9ABC, 1'b1);
    check("t4_otpt", otpt_a, 32'h56789ABC);

    // Counter wrap on the 4-bit instance.
    do_reset();
    for (int i = 0; i < 15; i++) begin
      step(1'b1, 16'(2 * i), 1'b1);
      step(1'b1, 16'(2 * i + 1), 1'b1);
    end
    step(1'b0, 16'h0, 1'b1);
    check("t5_cnt_b_max", 32'(cnt_b), 32'hF);
    step(1'b1, 16'hAAAA, 1'b1);
    step(1'b1, 16'h5555, 1'b1);
    step(1'b0, 16'h0, 1'b1);
    check("t5_cnt_b_wrap", 32'(cnt_b), 32'h0);
    check("t5_cnt_a", 32'(cnt_a), 32'd16);

    // Randomized traffic; the source holds its data while refused.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      bit          v;
      bit          r;
      logic [15:0] d;
      r = (i % 500 < 250) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      if (IN_VALID && !m_acc) begin
        v = 1'b1;
        d = INPT;
      end else begin
        v = ($urandom_range(0, 3) != 0);
        d = 16'($urandom);
      end
      step(v, d, r);
    end
    step(1'b0, 16'h0, 1'b1);
    step(1'b0, 16'h0, 1'b1);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
